// File: rtl/port_uart_tx.sv
// port_uart_tx
//   Output-port UART transmitter. Bytes written by the core through its 8-bit
//   output port are queued in a small FIFO and sent as 8N1 serial, LSB first.
//   A registered status byte goes back to the core's input port so software
//   can poll for space before writing.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous, active-high reset
//   out_port  byte from the core's output port register
//   out_we    one-cycle strobe: out_port holds a new byte
//   ovf_clr   clears the sticky overflow flag
//   tx        serial line, idles high
//   status    {count[3:0] (saturated at 15), ovf, busy, empty, full}
module port_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] out_port,
  input  logic       out_we,
  input  logic       ovf_clr,
  output logic       tx,
  output logic [7:0] status
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int CNTW = AW + 1;
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q, count_d;
  logic [CW-1:0]   baud_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            tx_q, busy_q, ovf_q, ovf_d, full_q, empty_q;
  logic [3:0]      cnt_sat_q, cnt_sat_d;
  logic            pop, push, drop;

  // A pop frees a slot on the same edge, so a full FIFO can still accept.
  assign pop  = (state_q == IDLE) && (count_q != '0);
  assign push = out_we && ((count_q != DEPTH_CNT) || pop);
  assign drop = out_we && !push;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // A new overflow wins over a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Status count field saturates at 15 regardless of FIFO depth.
  if (CNTW > 4) begin : g_cnt_sat
    assign cnt_sat_d = (count_d > CNTW'(15)) ? 4'hF : count_d[3:0];
  end else if (CNTW == 4) begin : g_cnt_eq
    assign cnt_sat_d = count_d;
  end else begin : g_cnt_pad
    assign cnt_sat_d = {{(4-CNTW){1'b0}}, count_d};
  end

  // FIFO storage: no reset, contents are dead once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= out_port;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      cnt_sat_q <= 4'h0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      full_q    <= (count_d == DEPTH_CNT);
      empty_q   <= (count_d == '0);
      cnt_sat_q <= cnt_sat_d;
    end
  end

  // Transmit FSM; tx and busy are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= DATA;
            tx_q      <= shift_q[0];
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx     = tx_q;
  assign status = {cnt_sat_q, ovf_q, busy_q, empty_q, full_q};

endmodule

// File: tb/tb_port_uart_tx.sv
// tb_port_uart_tx
//   Directed scenarios plus a random phase for port_uart_tx. A queue-based
//   reference model (FIFO as a queue, frame as a cycle timer) predicts tx and
//   status every cycle; a line decoder rebuilds the sent bytes from tx.
module tb_port_uart_tx;

  localparam int C = 4;
  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic [7:0] out_port;
  logic       out_we;
  logic       ovf_clr;
  logic       tx;
  logic [7:0] status;

  port_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .out_port(out_port), .out_we(out_we),
    .ovf_clr(ovf_clr), .tx(tx), .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int busy_cycles = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic [7:0] m_sent[$];
  bit         m_busy;
  int         m_t;
  logic [7:0] m_cur;
  bit         m_ovf;

  logic       tx_hist[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  function automatic void model_reset();
    mq.delete();
    m_sent.delete();
    m_busy = 0;
    m_t    = 0;
    m_cur  = 8'h00;
    m_ovf  = 0;
  endfunction

  function automatic void model_step(bit we, logic [7:0] d, bit clr);
    bit pop_now, acc;
    pop_now = !m_busy && (mq.size() > 0);
    acc     = we && ((mq.size() < D) || pop_now);
    if (m_busy) begin
      m_t++;
      if (m_t == 10*C) m_busy = 0;
    end else if (pop_now) begin
      m_cur  = mq.pop_front();
      m_busy = 1;
      m_t    = 0;
      m_sent.push_back(m_cur);
    end
    if (acc) mq.push_back(d);
    if (we && !acc) m_ovf = 1;
    else if (clr)   m_ovf = 0;
  endfunction

  function automatic logic model_tx();
    if (!m_busy)     return 1'b1;
    if (m_t < C)     return 1'b0;
    if (m_t < 9*C)   return m_cur[(m_t - C) / C];
    return 1'b1;
  endfunction

  function automatic logic [7:0] model_status();
    int n;
    logic [3:0] c;
    n = mq.size();
    c = (n > 15) ? 4'hF : 4'(n);
    return {c, m_ovf, m_busy, (n == 0), (n == D)};
  endfunction

  // Rebuild bytes from one tx sample per cycle.
  function automatic void decode();
    int i;
    logic [7:0] b;
    rx_q.delete();
    i = 0;
    while (i + 10*C <= tx_hist.size()) begin
      if (tx_hist[i] === 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = tx_hist[i + C*(k+1) + C/2];
        rx_q.push_back(b);
        i += 10*C;
      end else begin
        i++;
      end
    end
  endfunction

  task automatic chk8(string tag, logic [7:0] obs, logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_frames(string tag);
    decode();
    chk8({tag, "_nframes"}, 8'(rx_q.size()), 8'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      chk8($sformatf("%s_frame%0d", tag, i), rx_q[i], exp_q[i]);
  endtask

  task automatic tick();
    logic       etx;
    logic [7:0] est;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(out_we, out_port, ovf_clr);
    #1;
    tx_hist.push_back(tx);
    if (status[2] === 1'b1) busy_cycles++;
    etx = model_tx();
    est = model_status();
    vectors++;
    assert (tx === etx) else begin
      miscompares++;
      $error("FAIL tx cyc=%0d observed=%b expected=%b", cyc, tx, etx);
    end
    vectors++;
    assert (status === est) else begin
      miscompares++;
      $error("FAIL status cyc=%0d observed=%h expected=%h", cyc, status, est);
    end
    out_we  = 1'b0;
    ovf_clr = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tx_hist.delete();
    exp_q.delete();
  endtask

  task automatic write(logic [7:0] b);
    out_we   = 1'b1;
    out_port = b;
    tick();
  endtask

  task automatic drain(string tag, int budget);
    int n = 0;
    while ((m_busy || mq.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    assert (n < budget) else begin
      miscompares++;
      $error("FAIL %s_timeout observed=%0d expected<%0d", tag, n, budget);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; out_port = 8'h00; out_we = 1'b0; ovf_clr = 1'b0;
    model_reset();

    // Reset state
    do_reset();
    chk8("reset_status", status, 8'h02);
    chk8("reset_tx", {7'b0, tx}, 8'h01);

    // 1: single byte
    busy_cycles = 0;
    write(8'hA5);
    chk8("t1_status_after_push", status, 8'h10);
    drain("t1", 100);
    tick();
    chk8("t1_busy_cycles", 8'(busy_cycles), 8'd40);
    chk8("t1_status_end", status, 8'h02);
    exp_q = '{8'hA5};
    check_frames("t1");

    // 2: fill and overflow
    do_reset();
    for (int v = 1; v <= 5; v++) write(8'(v));
    chk8("t2_status_full", status, 8'h45);
    write(8'h06);
    chk8("t2_ovf", {7'b0, status[3]}, 8'h01);
    drain("t2", 400);
    tick();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_frames("t2");

    // 3: push into full FIFO on the pop edge
    do_reset();
    for (int v = 0; v < 5; v++) write(8'(8'h31 + v));
    n = 0;
    while (m_busy && n < 100) begin tick(); n++; end
    chk8("t3_reach_idle", {7'b0, m_busy}, 8'h00);
    write(8'h77);
    chk8("t3_status_pop_push", status, 8'h45);
    drain("t3", 400);
    tick();
    exp_q = '{8'h32, 8'h33, 8'h34, 8'h35, 8'h77};
    exp_q.push_front(8'h31);
    check_frames("t3");

    // 4: overflow vs clear on the same edge
    do_reset();
    for (int v = 0; v < 5; v++) write(8'(8'h41 + v));
    out_we = 1'b1; out_port = 8'h46; ovf_clr = 1'b1;
    tick();
    chk8("t4_ovf_race", {7'b0, status[3]}, 8'h01);
    ovf_clr = 1'b1;
    tick();
    chk8("t4_ovf_clear", {7'b0, status[3]}, 8'h00);
    drain("t4", 400);

    // 5: asynchronous reset during data bit 3
    do_reset();
    write(8'hFF);
    write(8'hAA);
    write(8'hBB);
    n = 0;
    while (!(m_busy && m_t == 4*C + 1) && n < 200) begin tick(); n++; end
    chk8("t5_reach_bit3", {7'b0, tx}, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk8("t5_async_tx", {7'b0, tx}, 8'h01);
    chk8("t5_async_status", status, 8'h02);
    model_reset();
    tick();
    rst = 1'b0;
    tx_hist.delete();
    repeat (60) tick();
    exp_q.delete();
    check_frames("t5");

    // 6: pointer wrap with spaced writes
    do_reset();
    for (int v = 0; v < 12; v++) begin
      write(8'(8'h10 + v));
      exp_q.push_back(8'(8'h10 + v));
      repeat (44) tick();
      chk8($sformatf("t6_no_ovf%0d", v), {7'b0, status[3]}, 8'h00);
    end
    drain("t6", 200);
    tick();
    check_frames("t6");

    // Random traffic against the model
    do_reset();
    repeat (600) begin
      out_we   = ($urandom_range(0, 7) == 0);
      out_port = 8'($urandom);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      tick();
    end
    drain("rand", 1000);
    tick();
    exp_q = m_sent;
    check_frames("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
